// File: rtl/rr_decoder_arbiter.sv
// Round-robin owner arbitration for a shared 2-to-4 one-hot decoder.
// Grants are registered, timed out after HOLD_MAX cycles and separated by one blank cycle.
module rr_decoder_arbiter #(
    parameter int SEL_W    = 2,
    parameter int HOLD_MAX = 15,
    localparam int N       = 2 ** SEL_W,
    localparam int CNT_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             dec_off,
    output logic             busy,
    output logic             tmo
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             r_state, w_nstate;
    logic [SEL_W-1:0]   r_ptr, w_ptr;
    logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt;
    logic [N-1:0]       r_gnt, w_gnt;
    logic [SEL_W-1:0]   r_sel, w_sel;
    logic               r_dec_off, w_dec_off;
    logic               r_busy, w_busy;
    logic               r_tmo, w_tmo;

    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic [SEL_W-1:0]   w_cand;
    logic               w_to;
    logic               w_owner_done;
    logic               w_owner_req;
    logic               w_release;

    // Rotating search starting at ptr; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_cand = r_ptr + SEL_W'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    generate
        if (HOLD_MAX != 0) begin : g_timeout
            assign w_to = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
        end else begin : g_no_timeout
            assign w_to = 1'b0;
        end
    endgenerate

    assign w_owner_done = done[r_sel];
    assign w_owner_req  = req[r_sel];
    assign w_release    = w_owner_done || !w_owner_req || w_to;

    always_comb begin
        w_nstate   = r_state;
        w_ptr      = r_ptr;
        w_hold_cnt = r_hold_cnt;
        w_gnt      = r_gnt;
        w_sel      = r_sel;
        w_dec_off  = r_dec_off;
        w_busy     = r_busy;
        w_tmo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nstate   = GRANT;
                    w_gnt      = N'(1) << w_idx;
                    w_sel      = w_idx;
                    w_dec_off  = 1'b0;
                    w_busy     = 1'b1;
                    w_hold_cnt = '0;
                end else begin
                    w_gnt     = '0;
                    w_dec_off = 1'b1;
                    w_busy    = 1'b0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    // sel stays on the old owner; dec_off already blanks the decoder.
                    w_nstate  = IDLE;
                    w_gnt     = '0;
                    w_dec_off = 1'b1;
                    w_busy    = 1'b0;
                    w_ptr     = r_sel + SEL_W'(1);
                    w_tmo     = w_to && !w_owner_done && w_owner_req;
                end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
                    w_hold_cnt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_dec_off  <= 1'b1;
            r_busy     <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_ptr      <= w_ptr;
            r_hold_cnt <= w_hold_cnt;
            r_gnt      <= w_gnt;
            r_sel      <= w_sel;
            r_dec_off  <= w_dec_off;
            r_busy     <= w_busy;
            r_tmo      <= w_tmo;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign dec_off = r_dec_off;
    assign busy    = r_busy;
    assign tmo     = r_tmo;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed scoreboard bench: the driver queues hand-computed post-edge outputs,
// a negedge monitor pops and compares them.
module tb_rr_decoder_arbiter;

    localparam int SEL_W    = 2;
    localparam int HOLD_MAX = 15;
    localparam int N        = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     done;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] sel;
    logic             dec_off;
    logic             busy;
    logic             tmo;

    typedef struct packed {
        logic [N-1:0]     gnt;
        logic [SEL_W-1:0] sel;
        logic             dec_off;
        logic             busy;
        logic             tmo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_vec    = 0;

    rr_decoder_arbiter #(.SEL_W(SEL_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .sel(sel), .dec_off(dec_off), .busy(busy), .tmo(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0h expected %0h", name, n_vec, act, expv);
        end
    endtask

    // Monitor: compare the DUT against each queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("gnt",     8'(gnt),     8'(e.gnt));
            chk("sel",     8'(sel),     8'(e.sel));
            chk("dec_off", 8'(dec_off), 8'(e.dec_off));
            chk("busy",    8'(busy),    8'(e.busy));
            chk("tmo",     8'(tmo),     8'(e.tmo));
            n_vec++;
        end
    end

    // Drive one edge's inputs and queue the outputs expected after that edge.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn,
                       input logic [N-1:0] eg, input logic [SEL_W-1:0] es, input logic et);
        exp_t e;
        rst  = r;
        req  = rq;
        done = dn;
        @(posedge clk);
        #1;
        e.gnt     = eg;
        e.sel     = es;
        e.dec_off = (eg == '0);
        e.busy    = (eg != '0);
        e.tmo     = et;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 4'b1111; done = 4'b0000;
        // Reset held two cycles with all requests up.
        cyc(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0);
        cyc(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0);
        // Rotation 0,1,2,3,0 with one idle cycle between owners.
        cyc(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0);
        cyc(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0);
        cyc(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0);
        cyc(0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 0);
        cyc(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0);
        cyc(0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 0);
        cyc(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0);
        cyc(0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 0);
        cyc(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0);
        // Non-owner done is ignored.
        cyc(0, 4'b1111, 4'b0010, 4'b0001, 2'd0, 0);
        cyc(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0);
        // ptr=1, req=1001 -> skip to 3, then wrap to 0.
        cyc(0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 0);
        cyc(0, 4'b1001, 4'b1000, 4'b0000, 2'd3, 0);
        cyc(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 0);
        // Release by dropping req; done in IDLE has no effect.
        cyc(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        cyc(0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0);
        // Timeout: exactly HOLD_MAX cycles of grant, then a tmo pulse.
        cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        for (int i = 0; i < HOLD_MAX - 1; i++)
            cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        cyc(0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1);
        cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        // done coinciding with timeout -> no tmo.
        for (int i = 0; i < HOLD_MAX - 1; i++)
            cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        cyc(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0);
        // Mid-grant reset drops the grant and clears ptr.
        cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        cyc(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        cyc(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0);
        cyc(0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 0);
        cyc(0, 4'b0110, 4'b0010, 4'b0000, 2'd1, 0);
        req = 4'b0000; done = 4'b0000;
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
